// File: rtl/i2c_cmd_scheduler.sv
// i2c_cmd_scheduler: orders every WM8731 register write sent to the shared
// I2C byte engine. The fixed init table is replayed on start; afterwards
// single runtime writes are accepted from one valid/ready requester.
// Build option: define I2C_SCHED_RETRY_EN to re-issue a NACKed frame up to
// MAX_RETRY times before giving up; without it any NACK ends in ERROR.
module i2c_cmd_scheduler #(
  parameter logic [7:0] DEV_ADDR  = 8'h34,
  parameter int         MAX_RETRY = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_req_valid,
  input  logic [15:0] i_req_data,
  output logic        o_req_ready,
  output logic        o_tx_valid,
  output logic [23:0] o_tx_data,
  input  logic        i_tx_ready,
  input  logic        i_tx_done,
  input  logic        i_tx_nack,
  output logic        o_init_done,
  output logic        o_busy,
  output logic        o_err
);

  localparam int N_INIT = 7;
  localparam logic [2:0] LAST_INDEX = 3'(N_INIT - 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    INIT_ISSUE,
    INIT_WAIT,
    READY,
    USR_ISSUE,
    USR_WAIT,
    ERROR
  } state_t;

  state_t state, next_state;
  logic [2:0]         index, next_index;
  logic [RETRY_W-1:0] retry_cnt, next_retry;
  logic [15:0]        usr_word, next_usr_word;
  logic               init_done_q, next_init_done;
  logic               err_q, next_err;
  logic               tx_valid_q, next_tx_valid;
  logic [23:0]        tx_data_q, next_tx_data;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 16'h1E00;
      3'd1:    init_word = 16'h0815;
      3'd2:    init_word = 16'h0A00;
      3'd3:    init_word = 16'h0C00;
      3'd4:    init_word = 16'h0E42;
      3'd5:    init_word = 16'h1019;
      3'd6:    init_word = 16'h1201;
      default: init_word = 16'h0000;
    endcase
  endfunction

  // State and datapath registers; the frame offer is registered so it is clean to the engine
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      index       <= '0;
      retry_cnt   <= '0;
      usr_word    <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state       <= next_state;
      index       <= next_index;
      retry_cnt   <= next_retry;
      usr_word    <= next_usr_word;
      init_done_q <= next_init_done;
      err_q       <= next_err;
      tx_valid_q  <= next_tx_valid;
      tx_data_q   <= next_tx_data;
    end
  end

  // Next-state logic: init sequence, runtime writes, NACK handling and the next frame offer
  always_comb begin
    next_state     = state;
    next_index     = index;
    next_retry     = retry_cnt;
    next_usr_word  = usr_word;
    next_init_done = init_done_q;
    next_err       = err_q;
    next_tx_valid  = 1'b0;
    next_tx_data   = '0;

    case (state)
      IDLE, ERROR: begin
        if (i_start) begin
          next_index     = '0;
          next_retry     = '0;
          next_init_done = 1'b0;
          next_err       = 1'b0;
          next_state     = INIT_ISSUE;
        end
      end
      INIT_ISSUE: begin
        if (tx_valid_q && i_tx_ready) next_state = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (i_tx_done && !i_tx_nack) begin
          next_retry = '0;
          if (index == LAST_INDEX) begin
            next_init_done = 1'b1;
            next_state     = READY;
          end else begin
            next_index = index + 3'd1;
            next_state = INIT_ISSUE;
          end
        end
      end
      READY: begin
        if (i_start) begin
          next_index     = '0;
          next_retry     = '0;
          next_init_done = 1'b0;
          next_err       = 1'b0;
          next_state     = INIT_ISSUE;
        end else if (i_req_valid) begin
          next_usr_word = i_req_data;
          next_state    = USR_ISSUE;
        end
      end
      USR_ISSUE: begin
        if (tx_valid_q && i_tx_ready) next_state = USR_WAIT;
      end
      USR_WAIT: begin
        if (i_tx_done && !i_tx_nack) begin
          next_retry = '0;
          next_state = READY;
        end
      end
      default: next_state = IDLE;
    endcase

    if ((state == INIT_WAIT || state == USR_WAIT) && i_tx_done && i_tx_nack) begin
`ifdef I2C_SCHED_RETRY_EN
      if (retry_cnt < RETRY_MAX) begin
        next_retry = retry_cnt + RETRY_W'(1);
        next_state = (state == INIT_WAIT) ? INIT_ISSUE : USR_ISSUE;
      end else begin
        next_err   = 1'b1;
        next_state = ERROR;
      end
`else
      next_err   = 1'b1;
      next_state = ERROR;
`endif
    end

    if (next_state == INIT_ISSUE) begin
      next_tx_valid = 1'b1;
      next_tx_data  = {DEV_ADDR, init_word(next_index)};
    end else if (next_state == USR_ISSUE) begin
      next_tx_valid = 1'b1;
      next_tx_data  = {DEV_ADDR, next_usr_word};
    end
  end

  // A simultaneous start wins over a runtime request, so ready is masked by i_start
  always_comb begin
    o_req_ready = (state == READY) && !i_start;
    o_busy      = !(state == IDLE || state == READY || state == ERROR);
  end

  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = tx_data_q;
  assign o_init_done = init_done_q;
  assign o_err       = err_q;

endmodule
